// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command controller: FSM states, opcode
// field positions and the default identification value.
package spi_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WDATA,
    RDATA,
    DISCARD
  } state_t;

  localparam int unsigned OP_WR_BIT  = 7;
  localparam int unsigned OP_RSVD_HI = 6;
  localparam int unsigned OP_RSVD_LO = 4;
  localparam int unsigned OP_ADDR_HI = 3;

  localparam logic [7:0] ID_VALUE_DEFAULT = 8'hA5;

endpackage

// File: rtl/spi_cfg_regfile.sv
// Configuration register file: one synchronous write port, all registers on a
// flat read bus. The top register is a read-only identification constant.
module spi_cfg_regfile
  import spi_cmd_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter logic [7:0]  ID_VALUE = ID_VALUE_DEFAULT,
  localparam int unsigned AW      = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [7:0]            wdata,
  output logic [NUM_REGS*8-1:0] cfg_flat
);

  localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);

  logic [7:0] regs [NUM_REGS-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS - 1; i++) regs[i] <= '0;
    end else if (we && waddr != LAST) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    cfg_flat = '0;
    for (int unsigned i = 0; i < NUM_REGS - 1; i++) cfg_flat[i*8 +: 8] = regs[i];
    cfg_flat[(NUM_REGS-1)*8 +: 8] = ID_VALUE;
  end

endmodule

// File: rtl/spi_cmd_controller.sv
// SPI command decoder driving a config register file. Define
// SPI_CMD_AUTOINC_EN to auto-increment the address on every data byte.
module spi_cmd_controller
  import spi_cmd_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter logic [7:0]  ID_VALUE = ID_VALUE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ss,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_valid,
  output logic [7:0]            tx_byte,
  output logic                  tx_load,
  output logic [NUM_REGS*8-1:0] cfg_flat,
  output logic                  cfg_update,
  output logic                  cmd_err
);

  localparam int unsigned   AW   = $clog2(NUM_REGS);
  localparam logic [AW-1:0] LAST = AW'(NUM_REGS - 1);
`ifdef SPI_CMD_AUTOINC_EN
  localparam logic AUTOINC = 1'b1;
`else
  localparam logic AUTOINC = 1'b0;
`endif

  state_t        state;
  logic [AW-1:0] addr;
  logic          armed;
  logic          done;
  logic          cmd_legal;
  logic [AW-1:0] cmd_addr;
  logic [AW-1:0] next_addr;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          wr_en;

  assign cmd_legal = (rx_byte[OP_RSVD_HI:OP_RSVD_LO] == 3'b000) &&
                     (32'(rx_byte[OP_ADDR_HI:0]) < NUM_REGS);
  assign cmd_addr  = rx_byte[AW-1:0];
  assign next_addr = (addr == LAST) ? '0 : addr + AW'(1);
  assign rd_addr   = (state == CMD) ? cmd_addr : next_addr;
  assign wr_en     = rx_valid && !ss && (state == WDATA) && !done;

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if (rd_addr == AW'(i)) rd_data = cfg_flat[i*8 +: 8];
  end

  spi_cfg_regfile #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (wr_en),
    .waddr    (addr),
    .wdata    (rx_byte),
    .cfg_flat (cfg_flat)
  );

  // armed stays low after reset until ss is seen high, so a frame cut by
  // reset cannot resume mid-stream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      armed      <= 1'b0;
      done       <= 1'b0;
      tx_byte    <= '0;
      tx_load    <= 1'b0;
      cfg_update <= 1'b0;
      cmd_err    <= 1'b0;
    end else begin
      tx_load    <= 1'b0;
      cfg_update <= 1'b0;
      if (ss) begin
        state   <= IDLE;
        armed   <= 1'b1;
        done    <= 1'b0;
        tx_byte <= '0;
      end else begin
        case (state)
          IDLE: if (armed) state <= CMD;
          CMD: if (rx_valid) begin
            if (!cmd_legal) begin
              cmd_err <= 1'b1;
              state   <= DISCARD;
            end else begin
              addr <= cmd_addr;
              done <= 1'b0;
              if (rx_byte[OP_WR_BIT]) begin
                state <= WDATA;
              end else begin
                state   <= RDATA;
                tx_byte <= rd_data;
                tx_load <= 1'b1;
              end
            end
          end
          WDATA: if (rx_valid && !done) begin
            cfg_update <= (addr != LAST);
            addr       <= next_addr;
            done       <= !AUTOINC;
          end
          RDATA: if (rx_valid && !done) begin
            tx_byte <= rd_data;
            tx_load <= 1'b1;
            addr    <= next_addr;
            done    <= !AUTOINC;
          end
          DISCARD: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
